mem_arbiter: RTL and testbench

Two-requester arbiter that shares the core's single memory port between instruction fetch (IF) and data load/store (D).
- Sits between the multicycle control/datapath and the memory.
- The control unit's fetch and memory steps both issue requests here and wait on their per-requester ready pulse.
- Registered outputs; one outstanding memory transaction at a time; round-robin under contention.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, grant ids, default widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter; master = arbiter side, slave = environment side.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
  logic                iIF_Req;
  logic [ADDR_W-1:0]   iIF_Addr;
  logic                oIF_Rdy;
  logic [DATA_W-1:0]   oIF_Data;

  logic                iD_Req;
  logic                iD_We;
  logic [ADDR_W-1:0]   iD_Addr;
  logic [DATA_W-1:0]   iD_WData;
  logic [DATA_W/8-1:0] iD_Be;
  logic                oD_Rdy;
  logic [DATA_W-1:0]   oD_RData;

  logic                oMem_Req;
  logic                oMem_We;
  logic [ADDR_W-1:0]   oMem_Addr;
  logic [DATA_W-1:0]   oMem_WData;
  logic [DATA_W/8-1:0] oMem_Be;
  logic                iMem_Rdy;
  logic [DATA_W-1:0]   iMem_RData;

  logic                oBusy;
  logic                oErr;

  modport master (
    input  iIF_Req, iIF_Addr, iD_Req, iD_We, iD_Addr, iD_WData, iD_Be, iMem_Rdy, iMem_RData,
    output oIF_Rdy, oIF_Data, oD_Rdy, oD_RData, oMem_Req, oMem_We, oMem_Addr, oMem_WData,
           oMem_Be, oBusy, oErr
  );

  modport slave (
    output iIF_Req, iIF_Addr, iD_Req, iD_We, iD_Addr, iD_WData, iD_Be, iMem_Rdy, iMem_RData,
    input  oIF_Rdy, oIF_Data, oD_Rdy, oD_RData, oMem_Req, oMem_We, oMem_Addr, oMem_WData,
           oMem_Be, oBusy, oErr
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick, combinational (0 cycles); a lone requester always wins,
// a tie goes to the requester that was not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_d,
  input  gnt_t last_gnt,
  output logic gnt_vld,
  output gnt_t gnt_id
);

  always_comb begin
    gnt_vld = req_if | req_d;
    gnt_id  = GNT_IF;
    if (req_if && req_d) begin
      gnt_id = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
    end else if (req_d) begin
      gnt_id = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data, one access at a time, 3 cycles minimum;
// requesters hold Req until their Rdy pulse. MEM_ARB_TIMEOUT_EN bounds the memory wait to TIMEOUT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          iClk,
  input  logic          nRst,
  mem_arbiter_if.master bus
);
  localparam int BE_W = DATA_W / 8;

  if (((DATA_W % 8) != 0) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("mem_arbiter: DATA_W must be a multiple of 8 and TIMEOUT at least 1");
  end

  state_t              state;
  gnt_t                last_gnt;
  logic                gnt_vld;
  gnt_t                gnt_id;
  logic                req_if;
  logic                req_d;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [BE_W-1:0]     mem_be;
  logic                if_rdy;
  logic                d_rdy;
  logic [DATA_W-1:0]   if_data;
  logic [DATA_W-1:0]   d_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    wait_cnt;
  logic                err_q;
`endif

  // A requester still showing its Rdy is finishing, not asking again.
  assign req_if = bus.iIF_Req & ~if_rdy;
  assign req_d  = bus.iD_Req  & ~d_rdy;

  rr_arb2 u_rr_arb2 (
    .req_if   (req_if),
    .req_d    (req_d),
    .last_gnt (last_gnt),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      last_gnt  <= GNT_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdy    <= 1'b0;
      d_rdy     <= 1'b0;
      if_data   <= '0;
      d_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      if_rdy <= 1'b0;
      d_rdy  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            mem_req  <= 1'b1;
            last_gnt <= gnt_id;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (gnt_id == GNT_IF) begin
              mem_we    <= 1'b0;
              mem_addr  <= bus.iIF_Addr;
              mem_wdata <= '0;
              mem_be    <= '1;
              state     <= BUSY_IF;
            end else begin
              mem_we    <= bus.iD_We;
              mem_addr  <= bus.iD_Addr;
              mem_wdata <= bus.iD_WData;
              mem_be    <= bus.iD_We ? bus.iD_Be : '1;
              state     <= BUSY_D;
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          // Completion beats a timeout landing on the same edge.
          if (bus.iMem_Rdy) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (state == BUSY_IF) begin
              if_rdy  <= 1'b1;
              if_data <= bus.iMem_RData;
            end else begin
              d_rdy <= 1'b1;
              if (!mem_we) d_rdata <= bus.iMem_RData;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            state   <= RESP;
            err_q   <= 1'b1;
            if (state == BUSY_IF) if_rdy <= 1'b1;
            else                  d_rdy  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oMem_Req   = mem_req;
  assign bus.oMem_We    = mem_we;
  assign bus.oMem_Addr  = mem_addr;
  assign bus.oMem_WData = mem_wdata;
  assign bus.oMem_Be    = mem_be;
  assign bus.oIF_Rdy    = if_rdy;
  assign bus.oIF_Data   = if_data;
  assign bus.oD_Rdy     = d_rdy;
  assign bus.oD_RData   = d_rdata;
  assign bus.oBusy      = (state != IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.oErr       = err_q;
`else
  assign bus.oErr       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed scenarios, then random traffic.
module tb_mem_arbiter;

  localparam int TB_TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic iClk = 1'b0;
  logic nRst;
  always #5 iClk = ~iClk;

  mem_arbiter_if bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TO)) dut (
    .iClk (iClk),
    .nRst (nRst),
    .bus  (bus)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  // Reference model: the access on the memory port (if any) and who is being answered this cycle.
  txn_t        active[$];
  int          resp_of;
  bit          resp_err;
  int          just_rdy;
  bit          last_d;
  int          wait_cnt;
  logic [31:0] exp_if_data;
  logic [31:0] exp_d_rdata;

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    active.delete();
    resp_of     = -1;
    resp_err    = 1'b0;
    just_rdy    = -1;
    last_d      = 1'b0;
    wait_cnt    = 0;
    exp_if_data = '0;
    exp_d_rdata = '0;
  endtask

  task automatic model_update();
    txn_t t;
    int   prev;
    prev     = resp_of;
    just_rdy = resp_of;
    resp_of  = -1;
    resp_err = 1'b0;
    if (active.size() != 0) begin
      if (bus.iMem_Rdy) begin
        t = active.pop_front();
        resp_of = int'(t.is_d);
        if (!t.is_d)    exp_if_data = bus.iMem_RData;
        else if (!t.we) exp_d_rdata = bus.iMem_RData;
      end else begin
        wait_cnt++;
        if (TO_EN && wait_cnt == TB_TO) begin
          t = active.pop_front();
          resp_of  = int'(t.is_d);
          resp_err = 1'b1;
        end
      end
    end else if (prev == -1 && (bus.iIF_Req || bus.iD_Req)) begin
      t.is_d  = bus.iD_Req && (!bus.iIF_Req || !last_d);
      t.we    = t.is_d && bus.iD_We;
      t.addr  = t.is_d ? bus.iD_Addr : bus.iIF_Addr;
      t.wdata = bus.iD_WData;
      t.be    = t.we ? bus.iD_Be : 4'hF;
      last_d  = t.is_d;
      wait_cnt = 0;
      active.push_back(t);
    end
  endtask

  task automatic check_outputs();
    cmp("mem_req", 32'(bus.oMem_Req), 32'(active.size() != 0));
    cmp("if_rdy",  32'(bus.oIF_Rdy),  32'(resp_of == 0));
    cmp("d_rdy",   32'(bus.oD_Rdy),   32'(resp_of == 1));
    cmp("err",     32'(bus.oErr),     32'(resp_err));
    cmp("busy",    32'(bus.oBusy),    32'(active.size() != 0 || resp_of != -1));
    cmp("if_data", bus.oIF_Data, exp_if_data);
    cmp("d_rdata", bus.oD_RData, exp_d_rdata);
    if (active.size() != 0) begin
      cmp("mem_addr", bus.oMem_Addr, active[0].addr);
      cmp("mem_we",   32'(bus.oMem_We), 32'(active[0].we));
      cmp("mem_be",   32'(bus.oMem_Be), 32'(active[0].be));
      if (active[0].we) cmp("mem_wdata", bus.oMem_WData, active[0].wdata);
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge, drive 1 ns later.
  task automatic tick();
    @(negedge iClk);
    check_outputs();
    @(posedge iClk);
    if (nRst) model_update();
    #1;
  endtask

  // Grant a pending request, stall the memory 'waits' cycles, complete with rdata, then release the requester.
  task automatic serve(input int waits, input logic [31:0] rdata, output txn_t seen, output logic [2:0] flags);
    int who;
    tick();
    seen.is_d  = 1'b0;
    seen.addr  = bus.oMem_Addr;
    seen.we    = bus.oMem_We;
    seen.wdata = bus.oMem_WData;
    seen.be    = bus.oMem_Be;
    repeat (waits) tick();
    bus.iMem_Rdy   = 1'b1;
    bus.iMem_RData = rdata;
    tick();
    bus.iMem_Rdy = 1'b0;
    flags = {bus.oErr, bus.oD_Rdy, bus.oIF_Rdy};
    who   = resp_of;
    tick();
    if (who == 0)      bus.iIF_Req = 1'b0;
    else if (who == 1) bus.iD_Req  = 1'b0;
  endtask

  initial begin
    txn_t        seen;
    logic [2:0]  flags;
    int          pulses;
    logic [31:0] keep;

    nRst = 1'b0;
    bus.iIF_Req = 0; bus.iIF_Addr = 0; bus.iD_Req = 0; bus.iD_We = 0;
    bus.iD_Addr = 0; bus.iD_WData = 0; bus.iD_Be = 0; bus.iMem_Rdy = 0; bus.iMem_RData = 0;
    model_reset();
    tick();
    tick();
    nRst = 1'b1;

    // Single fetch, memory ready on the 3rd cycle of the request.
    bus.iIF_Req = 1'b1; bus.iIF_Addr = 32'h100;
    serve(2, 32'hDEADBEEF, seen, flags);
    cmp("t1_addr", seen.addr, 32'h100);
    cmp("t1_be", 32'(seen.be), 32'hF);
    cmp("t1_flags", 32'(flags), 32'b001);
    cmp("t1_data", bus.oIF_Data, 32'hDEADBEEF);

    // Contention: data first (last grant was fetch), then fetch, then data again.
    bus.iIF_Req = 1'b1; bus.iIF_Addr = 32'h200;
    bus.iD_Req  = 1'b1; bus.iD_We = 1'b0; bus.iD_Addr = 32'h400;
    serve(0, 32'h0000_0400, seen, flags);
    cmp("t2_first", seen.addr, 32'h400);
    serve(1, 32'h0000_0200, seen, flags);
    cmp("t2_second", seen.addr, 32'h200);
    bus.iIF_Req = 1'b1; bus.iD_Req = 1'b1;
    serve(0, 32'h0000_0401, seen, flags);
    cmp("t2_third", seen.addr, 32'h400);
    serve(0, 32'h0000_0201, seen, flags);

    // Store leaves load data untouched.
    bus.iD_Req = 1'b1; bus.iD_We = 1'b0; bus.iD_Addr = 32'h44;
    serve(1, 32'hCAFEF00D, seen, flags);
    bus.iD_Req = 1'b1; bus.iD_We = 1'b1; bus.iD_Addr = 32'h40;
    bus.iD_WData = 32'h12345678; bus.iD_Be = 4'b0011;
    serve(2, 32'h55555555, seen, flags);
    cmp("t3_we", 32'(seen.we), 32'd1);
    cmp("t3_wdata", seen.wdata, 32'h12345678);
    cmp("t3_be", 32'(seen.be), 32'b0011);
    cmp("t3_flags", 32'(flags), 32'b010);
    cmp("t3_rdata_kept", bus.oD_RData, 32'hCAFEF00D);
    bus.iD_We = 1'b0;

    // Back-to-back fetches with an always-ready memory: one access every 3 cycles.
    bus.iIF_Req = 1'b1; bus.iIF_Addr = 32'h1000; bus.iMem_Rdy = 1'b1; pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.iMem_RData = $urandom;
      if (just_rdy == 0) bus.iIF_Addr = bus.iIF_Addr + 32'd4;
      if (bus.oIF_Rdy) pulses++;
    end
    bus.iIF_Req = 1'b0; bus.iMem_Rdy = 1'b0;
    cmp("t4_pulses", 32'(pulses), 32'd3);
    tick(); tick();
    cmp("t4_no_dup", 32'(bus.oMem_Req), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout after 8 busy cycles; completion on the 8th cycle wins.
    keep = bus.oIF_Data;
    bus.iIF_Req = 1'b1; bus.iIF_Addr = 32'h600;
    tick();
    repeat (7) tick();
    cmp("t6_req_held", 32'(bus.oMem_Req), 32'd1);
    tick();
    cmp("t6_rdy_err", 32'({bus.oIF_Rdy, bus.oErr}), 32'b11);
    cmp("t6_data_kept", bus.oIF_Data, keep);
    tick();
    bus.iIF_Req = 1'b0;
    tick();
    bus.iIF_Req = 1'b1;
    serve(7, 32'hA5A50008, seen, flags);
    cmp("t6_late_flags", 32'(flags), 32'b001);
    cmp("t6_late_data", bus.oIF_Data, 32'hA5A50008);
`endif

    // Asynchronous reset in the middle of a data access.
    bus.iD_Req = 1'b1; bus.iD_We = 1'b0; bus.iD_Addr = 32'h80;
    tick();
    cmp("t5_pre_req", 32'(bus.oMem_Req), 32'd1);
    #2 nRst = 1'b0;
    #1;
    cmp("t5_outs_zero", 32'(|{bus.oIF_Rdy, bus.oIF_Data, bus.oD_Rdy, bus.oD_RData, bus.oMem_Req,
                              bus.oMem_We, bus.oMem_Addr, bus.oMem_WData, bus.oMem_Be, bus.oBusy,
                              bus.oErr}), 32'd0);
    model_reset();
    bus.iD_Req = 1'b0;
    tick();
    nRst = 1'b1;
    bus.iIF_Req = 1'b1; bus.iIF_Addr = 32'h300;
    bus.iD_Req  = 1'b1; bus.iD_Addr  = 32'h500;
    serve(0, 32'h11112222, seen, flags);
    cmp("t5_regrant_d", seen.addr, 32'h500);
    serve(0, 32'h33334444, seen, flags);
    cmp("t5_then_if", seen.addr, 32'h300);

    // Random traffic from both requesters against a randomly stalling memory.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (just_rdy == 0) begin
        if ($urandom_range(0, 3) == 0) bus.iIF_Addr = $urandom & 32'hFFFF_FFFC;
        else                           bus.iIF_Req  = 1'b0;
      end else if (!bus.iIF_Req && $urandom_range(0, 2) == 0) begin
        bus.iIF_Req  = 1'b1;
        bus.iIF_Addr = $urandom & 32'hFFFF_FFFC;
      end
      if (just_rdy == 1 && $urandom_range(0, 3) != 0) begin
        bus.iD_Req = 1'b0;
      end else if (just_rdy == 1 || (!bus.iD_Req && $urandom_range(0, 2) == 0)) begin
        bus.iD_Req   = 1'b1;
        bus.iD_We    = 1'($urandom_range(0, 1));
        bus.iD_Addr  = $urandom;
        bus.iD_WData = $urandom;
        bus.iD_Be    = 4'($urandom_range(0, 15));
      end
      bus.iMem_Rdy   = ($urandom_range(0, 9) < 4);
      bus.iMem_RData = $urandom;
    end

    bus.iIF_Req = 1'b0; bus.iD_Req = 1'b0; bus.iMem_Rdy = 1'b1;
    repeat (6) tick();
    cmp("drain_idle", 32'(bus.oBusy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
